// File: rtl/control_flow_sequencer_pkg.sv
// Shared encodings for the control-flow sequencer: opcodes, frame types,
// frame field offsets and the sequencer state type.
package control_flow_sequencer_pkg;

  localparam int FRAME_W  = 15;
  localparam int TAG_W    = 4;
  localparam int ADDR_W   = 8;
  localparam int LBL_W    = 8;

  localparam int TYPE_HI  = 14;
  localparam int TYPE_LO  = 13;
  localparam int RET_BIT  = 12;
  localparam int TAG_HI   = 11;
  localparam int TAG_LO   = 8;
  localparam int EXTRA_HI = 7;
  localparam int EXTRA_LO = 0;

  typedef enum logic [3:0] {
    OP_OTHER  = 4'd0,
    OP_BLOCK  = 4'd1,
    OP_LOOP   = 4'd2,
    OP_IF     = 4'd3,
    OP_ELSE   = 4'd4,
    OP_END    = 4'd5,
    OP_BR     = 4'd6,
    OP_BR_IF  = 4'd7,
    OP_CALL   = 4'd8,
    OP_RETURN = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    FT_BLOCK = 2'b00,
    FT_CALL  = 2'b01,
    FT_IF    = 2'b10,
    FT_LOOP  = 2'b11
  } ftype_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BR_POP = 2'd1,
    ST_SKIP   = 2'd2
  } state_e;

  function automatic logic [FRAME_W-1:0] make_frame(input ftype_e t, input logic r,
                                                    input logic [TAG_W-1:0] tag,
                                                    input logic [ADDR_W-1:0] extra);
    return {t, r, tag, extra};
  endfunction

endpackage

// File: rtl/control_flow_sequencer_skip_scanner.sv
// Forward skip scan: tracks nesting depth d of discarded instructions and
// flags the end (d=0) or else (d=0, stop_else) that terminates the scan.
module control_flow_sequencer_skip_scanner
  import control_flow_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_stop_else,
  input  logic [LBL_W-1:0] load_d,
  input  logic             active,
  input  op_e              op,
  output logic             end_hit,
  output logic             else_hit
);

  logic [LBL_W-1:0] d_q, d_d;
  logic             stop_else_q, stop_else_d;

  always_comb begin
    d_d         = d_q;
    stop_else_d = stop_else_q;
    end_hit     = active && (op == OP_END) && (d_q == '0);
    else_hit    = active && (op == OP_ELSE) && (d_q == '0) && stop_else_q;
    if (load) begin
      d_d         = load_d;
      stop_else_d = load_stop_else;
    end else if (active) begin
      unique case (op)
        // Depth saturates so a pathological nest cannot wrap and end early.
        OP_BLOCK, OP_LOOP, OP_IF: if (d_q != '1) d_d = d_q + LBL_W'(1);
        OP_END:                   if (d_q != '0) d_d = d_q - LBL_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q         <= '0;
      stop_else_q <= 1'b0;
    end else begin
      d_q         <= d_d;
      stop_else_q <= stop_else_d;
    end
  end

endmodule

// File: rtl/control_flow_sequencer.sv
// Structured control-flow sequencer: decodes block/loop/if/else/end/br/call/
// return, drives control-stack commands and PC redirects.
module control_flow_sequencer
  import control_flow_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [3:0]         instr_op,
  input  logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_cond,
  input  logic [LBL_W-1:0]   instr_label,
  input  logic               instr_ret,
  input  logic [ADDR_W-1:0]  call_target,
  input  logic [TAG_W-1:0]   cur_tag,
  output logic               cs_push,
  output logic               cs_pop,
  output logic               cs_return,
  output logic               cs_function_call,
  output logic [FRAME_W-1:0] cs_push_data,
  input  logic [FRAME_W-1:0] cs_top_data,
  input  logic               cs_left_one,
  output logic               pc_redirect_valid,
  output logic [ADDR_W-1:0]  pc_redirect_addr,
  output logic               prog_done,
  output logic               underflow_err,
  output state_e             dbg_state
);

  // Handshake: an instruction transfers when instr_valid && instr_ready at a
  // rising edge; ready is low only while popping frames for a branch.
  state_e           state_q, state_d;
  logic [LBL_W-1:0] cnt_q, cnt_d, lbl_q, lbl_d;
  logic             empty_q, empty_d, err_q, err_d;
  logic             accept, pop_req, ret_req, pop_ok;
  logic             redir_req, redir_on_pop;
  logic [ADDR_W-1:0] redir_addr;
  logic             skip_load, skip_stop_else, end_hit, else_hit;
  logic [LBL_W-1:0] skip_load_d;
  op_e              op;
  ftype_e           top_type;
  logic [ADDR_W-1:0] top_extra;
  logic [RET_BIT-TAG_LO:0] unused_top_bits;

  assign op              = op_e'(instr_op);
  assign top_type        = ftype_e'(cs_top_data[TYPE_HI:TYPE_LO]);
  assign top_extra       = cs_top_data[EXTRA_HI:EXTRA_LO];
  assign unused_top_bits = cs_top_data[RET_BIT:TAG_LO];
  assign instr_ready     = (state_q != ST_BR_POP);
  assign accept          = instr_valid && instr_ready && !rst;
  assign dbg_state       = state_q;

  control_flow_sequencer_skip_scanner u_skip (
    .clk            (clk),
    .rst            (rst),
    .load           (skip_load),
    .load_stop_else (skip_stop_else),
    .load_d         (skip_load_d),
    .active         (accept && (state_q == ST_SKIP)),
    .op             (op),
    .end_hit        (end_hit),
    .else_hit       (else_hit)
  );

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    lbl_d            = lbl_q;
    cs_push          = 1'b0;
    cs_push_data     = '0;
    cs_function_call = 1'b0;
    pop_req          = 1'b0;
    ret_req          = 1'b0;
    redir_req        = 1'b0;
    redir_on_pop     = 1'b0;
    redir_addr       = '0;
    skip_load        = 1'b0;
    skip_stop_else   = 1'b0;
    skip_load_d      = '0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: if (accept) begin
          unique case (op)
            OP_BLOCK: begin
              cs_push      = 1'b1;
              cs_push_data = make_frame(FT_BLOCK, instr_ret, cur_tag, '0);
            end
            OP_LOOP: begin
              cs_push      = 1'b1;
              cs_push_data = make_frame(FT_LOOP, instr_ret, cur_tag, instr_pc + ADDR_W'(1));
            end
            OP_IF: begin
              cs_push      = 1'b1;
              cs_push_data = make_frame(FT_IF, instr_ret, cur_tag, '0);
              if (!instr_cond) begin
                state_d        = ST_SKIP;
                skip_load      = 1'b1;
                skip_stop_else = 1'b1;
              end
            end
            OP_ELSE: begin
              state_d   = ST_SKIP;
              skip_load = 1'b1;
            end
            OP_END: begin
              pop_req      = 1'b1;
              redir_on_pop = (top_type == FT_CALL);
              redir_addr   = top_extra;
            end
            OP_BR, OP_BR_IF: if (op == OP_BR || instr_cond) begin
              state_d = ST_BR_POP;
              cnt_d   = instr_label;
              lbl_d   = instr_label;
            end
            OP_CALL: begin
              cs_push          = 1'b1;
              cs_push_data     = make_frame(FT_CALL, instr_ret, cur_tag, instr_pc + ADDR_W'(1));
              cs_function_call = 1'b1;
              redir_req        = 1'b1;
              redir_addr       = call_target;
            end
            OP_RETURN: begin
              pop_req      = 1'b1;
              ret_req      = 1'b1;
              redir_on_pop = 1'b1;
              redir_addr   = top_extra;
            end
            default: ;
          endcase
        end
        ST_BR_POP: begin
          if (cnt_q != '0) begin
            pop_req = 1'b1;
            cnt_d   = cnt_q - LBL_W'(1);
          end else begin
            state_d = ST_RUN;
            unique case (top_type)
              FT_LOOP: begin
                redir_req  = 1'b1;
                redir_addr = top_extra;
              end
              FT_CALL: begin
                pop_req      = 1'b1;
                ret_req      = 1'b1;
                redir_on_pop = 1'b1;
                redir_addr   = top_extra;
              end
              default: begin
                // Target block/if: skip past the ends of the frames just popped.
                state_d     = ST_SKIP;
                skip_load   = 1'b1;
                skip_load_d = lbl_q;
              end
            endcase
          end
        end
        ST_SKIP: begin
          if (end_hit) begin
            pop_req = 1'b1;
            state_d = ST_RUN;
          end else if (else_hit) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // A pop on an empty stack is dropped, together with its return and redirect.
  assign pop_ok            = pop_req && !empty_q;
  assign cs_pop            = pop_ok;
  assign cs_return         = ret_req && pop_ok;
  assign pc_redirect_valid = redir_req || (redir_on_pop && pop_ok);
  assign pc_redirect_addr  = redir_addr;
  assign prog_done         = pop_ok && cs_left_one;
  assign underflow_err     = err_q;

  always_comb begin
    empty_d = empty_q;
    if (pop_ok && cs_left_one) empty_d = 1'b1;
    else if (cs_push)          empty_d = 1'b0;
    err_d = err_q || (pop_req && empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      lbl_q   <= '0;
      empty_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lbl_q   <= lbl_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

endmodule
